// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared types for the instruction/data bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY, RESP)
//   bus_req_t   : one latched memory transaction (we, addr, wdata, be)
//   fetch_req() : builds the bus request used for an instruction fetch
// The struct storage geometry is fixed here; ports of bus_arbiter are cast to
// and from it, so the port widths must not exceed these storage widths.
// -----------------------------------------------------------------------------
package rv_pkg;

   localparam int RV_ADDR_W = 32;
   localparam int RV_DATA_W = 32;
   localparam int RV_BE_W   = RV_DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic                 we;
      logic [RV_ADDR_W-1:0] addr;
      logic [RV_DATA_W-1:0] wdata;
      logic [RV_BE_W-1:0]   be;
   } bus_req_t;

   localparam bus_req_t BUS_REQ_NONE = '{
      we:    1'b0,
      addr:  {RV_ADDR_W{1'b0}},
      wdata: {RV_DATA_W{1'b0}},
      be:    {RV_BE_W{1'b0}}
   };

   // A fetch is always a full-word read.
   function automatic bus_req_t fetch_req(input logic [RV_ADDR_W-1:0] addr);
      fetch_req = '{
         we:    1'b0,
         addr:  addr,
         wdata: {RV_DATA_W{1'b0}},
         be:    {RV_BE_W{1'b1}}
      };
   endfunction

endpackage

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares one memory port between an instruction-fetch port and a data port.
// One transaction is outstanding at a time; a BUSY watchdog turns a missing
// ack into an error response.
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_if_req, i_if_addr              fetch request (held until o_if_valid)
//   o_if_valid, o_if_rdata           fetch completion pulse and data
//   i_mem_req/we/addr/wdata/be       data request (held until o_mem_valid)
//   o_mem_valid, o_mem_rdata         data completion pulse and read data
//   o_bus_req/we/addr/wdata/be       registered shared memory port
//   i_bus_ack, i_bus_rdata           memory completion and read data
//   o_bus_err                        pulse alongside the valid of a timeout
// -----------------------------------------------------------------------------
module bus_arbiter
   import rv_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 256
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_if_req,
   input  logic [ADDR_W-1:0]   i_if_addr,
   output logic                o_if_valid,
   output logic [DATA_W-1:0]   o_if_rdata,
   input  logic                i_mem_req,
   input  logic                i_mem_we,
   input  logic [ADDR_W-1:0]   i_mem_addr,
   input  logic [DATA_W-1:0]   i_mem_wdata,
   input  logic [DATA_W/8-1:0] i_mem_be,
   output logic                o_mem_valid,
   output logic [DATA_W-1:0]   o_mem_rdata,
   output logic                o_bus_req,
   output logic                o_bus_we,
   output logic [ADDR_W-1:0]   o_bus_addr,
   output logic [DATA_W-1:0]   o_bus_wdata,
   output logic [DATA_W/8-1:0] o_bus_be,
   input  logic                i_bus_ack,
   input  logic [DATA_W-1:0]   i_bus_rdata,
   output logic                o_bus_err
);

   // The counter must be able to hold TIMEOUT itself: an ack seen while the
   // count equals TIMEOUT still completes normally.
   localparam int              CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

   arb_state_t        state_q, state_d;
   bus_req_t          bus_q, bus_d;
   logic              bus_req_q, bus_req_d;
   logic              grant_data_q, grant_data_d;   // current grant is the data port
   logic              last_data_q, last_data_d;     // previous grant went to data
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              if_valid_q, if_valid_d;
   logic              mem_valid_q, mem_valid_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
   logic              bus_err_q, bus_err_d;
   logic              pick_data;
   logic [DATA_W-1:0] resp_data;

   // Next-state, arbitration, watchdog and response generation.
   always_comb begin
      state_d      = state_q;
      bus_d        = bus_q;
      bus_req_d    = bus_req_q;
      grant_data_d = grant_data_q;
      last_data_d  = last_data_q;
      cnt_d        = cnt_q;
      if_valid_d   = 1'b0;
      mem_valid_d  = 1'b0;
      if_rdata_d   = {DATA_W{1'b0}};
      mem_rdata_d  = {DATA_W{1'b0}};
      bus_err_d    = 1'b0;
      pick_data    = 1'b0;
      resp_data    = {DATA_W{1'b0}};

      case (state_q)
         IDLE: begin
            if (i_mem_req || i_if_req) begin
               // Data has priority, but yields to a waiting fetch right after
               // a data grant so instruction fetch cannot starve.
               pick_data    = i_mem_req && !(i_if_req && last_data_q);
               grant_data_d = pick_data;
               last_data_d  = pick_data;
               bus_req_d    = 1'b1;
               cnt_d        = {CNT_W{1'b0}};
               state_d      = BUSY;
               if (pick_data) begin
                  bus_d = '{
                     we:    i_mem_we,
                     addr:  RV_ADDR_W'(i_mem_addr),
                     wdata: RV_DATA_W'(i_mem_wdata),
                     be:    RV_BE_W'(i_mem_be)
                  };
               end else begin
                  bus_d = fetch_req(RV_ADDR_W'(i_if_addr));
               end
            end else begin
               bus_req_d = 1'b0;
            end
         end
         BUSY: begin
            if (i_bus_ack) begin
               resp_data   = bus_q.we ? {DATA_W{1'b0}} : i_bus_rdata;
               bus_req_d   = 1'b0;
               state_d     = RESP;
               if_valid_d  = !grant_data_q;
               mem_valid_d = grant_data_q;
               if_rdata_d  = grant_data_q ? {DATA_W{1'b0}} : resp_data;
               mem_rdata_d = grant_data_q ? resp_data : {DATA_W{1'b0}};
            end else if (cnt_q == CNT_LIMIT) begin
               // Watchdog expiry: complete with zero data and flag the error.
               bus_req_d   = 1'b0;
               state_d     = RESP;
               if_valid_d  = !grant_data_q;
               mem_valid_d = grant_data_q;
               bus_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= IDLE;
         bus_q        <= BUS_REQ_NONE;
         bus_req_q    <= 1'b0;
         grant_data_q <= 1'b0;
         last_data_q  <= 1'b0;
         cnt_q        <= {CNT_W{1'b0}};
         if_valid_q   <= 1'b0;
         mem_valid_q  <= 1'b0;
         if_rdata_q   <= {DATA_W{1'b0}};
         mem_rdata_q  <= {DATA_W{1'b0}};
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bus_q        <= bus_d;
         bus_req_q    <= bus_req_d;
         grant_data_q <= grant_data_d;
         last_data_q  <= last_data_d;
         cnt_q        <= cnt_d;
         if_valid_q   <= if_valid_d;
         mem_valid_q  <= mem_valid_d;
         if_rdata_q   <= if_rdata_d;
         mem_rdata_q  <= mem_rdata_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign o_bus_req   = bus_req_q;
   assign o_bus_we    = bus_q.we;
   assign o_bus_addr  = ADDR_W'(bus_q.addr);
   assign o_bus_wdata = DATA_W'(bus_q.wdata);
   assign o_bus_be    = (DATA_W/8)'(bus_q.be);
   assign o_if_valid  = if_valid_q;
   assign o_if_rdata  = if_rdata_q;
   assign o_mem_valid = mem_valid_q;
   assign o_mem_rdata = mem_rdata_q;
   assign o_bus_err   = bus_err_q;

endmodule
